seq_multiplier: RTL

8×8 unsigned shift-and-add multiplier producing a 16-bit product over 8 iterations, with a start/busy/done handshake. It is the sequential stage built around the existing 8-bit `Adder`. The adder computes each partial sum, and this block shifts the sum and carry into its product register.

---
 rtl/mult_pkg.sv | 13 +
 rtl/Adder.sv | 14 +
 rtl/seq_multiplier.sv | 82 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and sizing.
package mult_pkg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned ITER_LAST = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/Adder.sv
// Unsigned ripple adder with carry-in and carry-out; computes each partial sum.
module Adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C
);

  assign {oData_C, oData} = {1'b0, iData_a} + {1'b0, iData_b} + (WIDTH + 1)'(iC);

endmodule : Adder

// File: rtl/seq_multiplier.sv
// Sequential WIDTHxWIDTH unsigned multiplier: one shift-and-add step per cycle,
// start/busy/done handshake, result held in a register separate from the working product.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iData_a,
  input  logic [WIDTH-1:0]   iData_b,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oData
);

  localparam int unsigned     PROD_W = 2 * WIDTH;
  localparam int unsigned     CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t              r_state;
  logic [WIDTH-1:0]    r_mcand;
  logic [PROD_W-1:0]   r_prod;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROD_W-1:0]   r_data;

  logic [WIDTH-1:0]    w_sum;
  logic                w_carry;
  logic [PROD_W-1:0]   w_next;

  Adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .iData_a (r_prod[PROD_W-1:WIDTH]),
    .iData_b (r_mcand),
    .iC      (1'b0),
    .oData   (w_sum),
    .oData_C (w_carry)
  );

  // Add the multiplicand into the upper half only when the current multiplier bit is set.
  assign w_next = r_prod[0] ? {w_carry, w_sum, r_prod[WIDTH-1:1]}
                            : {1'b0, r_prod[PROD_W-1:WIDTH], r_prod[WIDTH-1:1]};

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (iStart) begin
            r_mcand <= iData_a;
            r_prod  <= {{WIDTH{1'b0}}, iData_b};
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_prod <= w_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_data  <= w_next;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oBusy = (r_state == RUN);
  assign oDone = (r_state == DONE);
  assign oData = r_data;

endmodule : seq_multiplier
